// File: rtl/tnoc_port_arbiter.sv
// Output-port arbiter: locks each VC to one input port per packet (round-robin) and picks one locked VC per cycle.
// o_grant is registered one cycle after a head request; o_vc_grant is combinational; stalled VCs simply stay unselected.
module tnoc_port_arbiter #(
  parameter int               CHANNELS        = 2,
  parameter int               PORTS           = 5,
  parameter logic [PORTS-1:0] AVAILABLE_PORTS = {PORTS{1'b1}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PORTS*CHANNELS-1:0]    i_request,
  input  logic [PORTS*CHANNELS-1:0]    i_free,
  input  logic [PORTS*CHANNELS-1:0]    i_start_of_packet,
  input  logic [PORTS*CHANNELS-1:0]    i_end_of_packet,
  input  logic [CHANNELS-1:0]          i_vc_available,
  output logic [PORTS*CHANNELS-1:0]    o_grant,
  output logic [CHANNELS-1:0]          o_vc_grant
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state   [CHANNELS];
  logic [PW-1:0]       owner   [CHANNELS];
  logic [PW-1:0]       rr      [CHANNELS];
  logic [PW-1:0]       win     [CHANNELS];
  logic [CW-1:0]       vc_ptr;
  logic [CW-1:0]       vc_sel;
  logic [CHANNELS-1:0] cand;
  logic [CHANNELS-1:0] own_req;
  logic [CHANNELS-1:0] own_free;
  logic [CHANNELS-1:0] own_eop;
  logic [CHANNELS-1:0] vc_ready;
  logic                vc_fire;

  // Round-robin search expressed as distance from rr+1 so every select index stays constant.
  always_comb begin : owner_lookup
    int d;
    int best;
    d        = 0;
    best     = 0;
    cand     = '0;
    own_req  = '0;
    own_free = '0;
    own_eop  = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      win[v] = '0;
      best   = PORTS;
      for (int p = 0; p < PORTS; p++) begin
        d = p - int'(rr[v]) - 1;
        if (d < 0) d = d + PORTS;
        if (AVAILABLE_PORTS[p] && i_request[p*CHANNELS+v] &&
            i_start_of_packet[p*CHANNELS+v] && (d < best)) begin
          best    = d;
          win[v]  = PW'(p);
          cand[v] = 1'b1;
        end
        if (owner[v] == PW'(p)) begin
          own_req[v]  = i_request[p*CHANNELS+v];
          own_free[v] = i_free[p*CHANNELS+v];
          own_eop[v]  = i_end_of_packet[p*CHANNELS+v];
        end
      end
    end
  end

  always_comb begin : vc_select
    int d;
    int best;
    d          = 0;
    best       = CHANNELS;
    vc_sel     = '0;
    vc_ready   = '0;
    o_vc_grant = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      vc_ready[v] = (state[v] == BUSY) && own_req[v] && i_vc_available[v];
      d = v - int'(vc_ptr) - 1;
      if (d < 0) d = d + CHANNELS;
      if (vc_ready[v] && (d < best)) begin
        best       = d;
        vc_sel     = CW'(v);
        o_vc_grant = '0;
        o_vc_grant[v] = 1'b1;
      end
    end
  end

  assign vc_fire = |(o_vc_grant & own_free);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < CHANNELS; v++) begin
        state[v] <= IDLE;
        owner[v] <= '0;
        rr[v]    <= PW'(PORTS - 1);
      end
      vc_ptr  <= CW'(CHANNELS - 1);
      o_grant <= '0;
    end else begin
      for (int v = 0; v < CHANNELS; v++) begin
        case (state[v])
          IDLE: begin
            if (cand[v]) begin
              state[v] <= BUSY;
              owner[v] <= win[v];
              rr[v]    <= win[v];
              for (int p = 0; p < PORTS; p++)
                o_grant[p*CHANNELS+v] <= (win[v] == PW'(p));
            end
          end
          BUSY: begin
            // Lock is held through owner request gaps; only its tail releases it.
            if (own_eop[v]) begin
              state[v] <= IDLE;
              for (int p = 0; p < PORTS; p++)
                o_grant[p*CHANNELS+v] <= 1'b0;
            end
          end
          default: state[v] <= IDLE;
        endcase
      end
      if (vc_fire) vc_ptr <= vc_sel;
    end
  end

endmodule

// File: tb/tb_tnoc_port_arbiter.sv
// Directed bench for tnoc_port_arbiter: behavioural requesters drive flits, checks use hand-computed grants.
module tb_tnoc_port_arbiter;
  localparam int C = 2;
  localparam int P = 5;
  localparam int N = P * C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0, free = '0, sop = '0, eop = '0;
  logic [C-1:0] vca = '0;
  logic [N-1:0] grant, grant_m;
  logic [C-1:0] vcg, vcg_m;

  int rem [N];
  bit started [N];
  bit use_m = 1'b0;
  int checks = 0;
  int errors = 0;

  // Expected o_grant for the three-requester VC0 sequence plus the follow-up round.
  logic [31:0] exp_g2 [17] = '{32'h000, 32'h001, 32'h001, 32'h001, 32'h000,
                               32'h004, 32'h004, 32'h004, 32'h000,
                               32'h040, 32'h040, 32'h040, 32'h000,
                               32'h000, 32'h001, 32'h000, 32'h004};

  always #5 clk = ~clk;

  tnoc_port_arbiter #(.CHANNELS(C), .PORTS(P), .AVAILABLE_PORTS(5'b11111)) dut (
    .clk(clk), .rst_n(rst_n), .i_request(req), .i_free(free),
    .i_start_of_packet(sop), .i_end_of_packet(eop), .i_vc_available(vca),
    .o_grant(grant), .o_vc_grant(vcg)
  );

  tnoc_port_arbiter #(.CHANNELS(C), .PORTS(P), .AVAILABLE_PORTS(5'b01111)) dut_m (
    .clk(clk), .rst_n(rst_n), .i_request(req), .i_free(free),
    .i_start_of_packet(sop), .i_end_of_packet(eop), .i_vc_available(vca),
    .o_grant(grant_m), .o_vc_grant(vcg_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      rem[i]     = 0;
      started[i] = 1'b0;
    end
    req  = '0;
    free = '0;
    sop  = '0;
    eop  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle of requester behaviour; returns at posedge+3 with outputs settled.
  task automatic step();
    logic [N-1:0] g;
    logic [C-1:0] vg;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (free[i]) begin
        rem[i]     = rem[i] - 1;
        started[i] = (rem[i] > 0);
      end
    end
    for (int i = 0; i < N; i++) begin
      req[i] = (rem[i] > 0);
      sop[i] = (rem[i] > 0) && !started[i];
    end
    #1;
    g  = use_m ? grant_m : grant;
    vg = use_m ? vcg_m : vcg;
    for (int p = 0; p < P; p++) begin
      for (int v = 0; v < C; v++) begin
        free[p*C+v] = req[p*C+v] && g[p*C+v] && vg[v];
        eop[p*C+v]  = free[p*C+v] && (rem[p*C+v] == 1);
      end
    end
    #1;
  endtask

  initial begin
    model_clear();
    #2;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_vcg", 32'(vcg), 32'h0);

    // Single-flit packet from port 2 on VC0.
    do_reset();
    vca = 2'b11;
    rem[2*C+0] = 1;
    step();
    check("t1_c0_grant", 32'(grant), 32'h000);
    check("t1_c0_vcg", 32'(vcg), 32'h0);
    step();
    check("t1_c1_grant", 32'(grant), 32'h010);
    check("t1_c1_vcg", 32'(vcg), 32'h1);
    step();
    check("t1_c2_grant", 32'(grant), 32'h000);

    // Ports 0,1,3 contend for VC0 with 3-flit packets, then a fresh round.
    do_reset();
    vca = 2'b01;
    rem[0*C+0] = 3;
    rem[1*C+0] = 3;
    rem[3*C+0] = 3;
    for (int c = 0; c < 17; c++) begin
      step();
      check($sformatf("t2_c%0d_grant", c), 32'(grant), exp_g2[c]);
      if (c == 1) check("t2_c1_vcg", 32'(vcg), 32'h1);
      if (c == 4) check("t2_c4_vcg", 32'(vcg), 32'h0);
      if (c == 12) begin
        rem[0*C+0] = 1;
        rem[1*C+0] = 1;
      end
    end

    // Port 1 on VC0 and port 4 on VC1 interleave flit by flit.
    do_reset();
    vca = 2'b11;
    rem[1*C+0] = 6;
    rem[4*C+1] = 6;
    step();
    check("t3_c0_grant", 32'(grant), 32'h000);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) check("t3_c1_grant", 32'(grant), 32'h204);
      check($sformatf("t3_c%0d_vcg", c), 32'(vcg), (c % 2 == 1) ? 32'h1 : 32'h2);
    end

    // VC1 downstream blocked: only VC0 flits move, VC1 lock persists.
    do_reset();
    vca = 2'b01;
    rem[1*C+0] = 6;
    rem[4*C+1] = 6;
    step();
    for (int c = 1; c <= 6; c++) begin
      step();
      check($sformatf("t4_c%0d_vcg", c), 32'(vcg), 32'h1);
      if (c == 3) check("t4_c3_grant", 32'(grant), 32'h204);
    end
    step();
    check("t4_c7_grant", 32'(grant), 32'h200);
    check("t4_c7_vcg", 32'(vcg), 32'h0);

    // Masked port 4 is never granted; port 0 still is.
    use_m = 1'b1;
    do_reset();
    vca = 2'b11;
    rem[4*C+0] = 2;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("t5_c%0d_grant", c), 32'(grant_m), 32'h000);
    end
    rem[0*C+0] = 1;
    step();
    check("t5_c4_grant", 32'(grant_m), 32'h000);
    step();
    check("t5_c5_grant", 32'(grant_m), 32'h001);
    check("t5_c5_vcg", 32'(vcg_m), 32'h1);
    step();
    check("t5_c6_grant", 32'(grant_m), 32'h000);
    use_m = 1'b0;

    // Asynchronous reset mid-packet, then arbitration restarts at port 0.
    do_reset();
    vca = 2'b11;
    rem[0*C+0] = 5;
    step();
    step();
    check("t6_busy_grant", 32'(grant), 32'h001);
    step();
    rst_n = 1'b0;
    #1;
    check("t6_arst_grant", 32'(grant), 32'h000);
    check("t6_arst_vcg", 32'(vcg), 32'h0);
    do_reset();
    rem[0*C+0] = 1;
    rem[1*C+0] = 1;
    step();
    step();
    check("t6_restart_grant", 32'(grant), 32'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
